// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: header field widths,
// address/length limits, FSM state encoding and small header helpers.
package router_pkg;

    localparam int LEN_W     = 6;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;
    localparam int MAX_LEN   = 63;
    localparam int BUF_DEPTH = MAX_LEN + 1;
    localparam int PTR_W     = 6;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_DONE    = 3'd5
    } tx_state_e;

    function automatic logic req_ok(input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] l);
        return (d != ADDR_INVALID) && (l != {LEN_W{1'b0}});
    endfunction

    // Header byte doubles as the parity seed, so both use this packing.
    function automatic logic [DATA_W-1:0] hdr_byte(input logic [LEN_W-1:0] l, input logic [ADDR_W-1:0] d);
        return {l, d};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 single-clock payload buffer with write/read pointers and a synchronous
// pointer clear. Read data is the entry at the current read pointer.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [PTR_W-1:0]  rd_ptr
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    // Pointer next-state; clear wins over any access.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 6'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 6'd1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
    end

    // Storage array; contents need no reset because pointers gate all reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then emits header, payload and
// XOR parity byte. ROUTER_TX_PARITY_INJ_EN enables parity bit-0 corruption via inj_err.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              pkt_valid,
    output logic              tx_busy,
    output logic              done,
    output logic              err,
    input  logic              inj_err
);

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              pl_ready_q, pl_ready_d;
    logic              tx_busy_q, tx_busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              buf_wr_s, buf_rd_s, buf_clr_s;
    logic [DATA_W-1:0] buf_rd_data_s;
    logic [PTR_W-1:0]  buf_wr_ptr_s, buf_rd_ptr_s;
    logic [DATA_W-1:0] par_out_s;

`ifdef ROUTER_TX_PARITY_INJ_EN
    assign par_out_s = par_q ^ {7'b0000000, inj_err};
`else
    logic unused_inj_s;
    assign unused_inj_s = inj_err;
    assign par_out_s    = par_q;
`endif

    assign buf_clr_s = rst | (state_q == S_IDLE);

    router_tx_buf u_buf (
        .clk     (clk),
        .clr     (buf_clr_s),
        .wr_en   (buf_wr_s),
        .wr_data (pl_data),
        .rd_en   (buf_rd_s),
        .rd_data (buf_rd_data_s),
        .wr_ptr  (buf_wr_ptr_s),
        .rd_ptr  (buf_rd_ptr_s)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        par_d       = par_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        pl_ready_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        buf_wr_s    = 1'b0;
        buf_rd_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_d      = 8'h00;
                pkt_valid_d = 1'b0;
                if (start && req_ok(dest, len)) begin
                    state_d    = S_LOAD;
                    dest_d     = dest;
                    len_d      = len;
                    par_d      = hdr_byte(len, dest);
                    pl_ready_d = 1'b1;
                end else begin
                    err_d = start;
                end
            end
            S_LOAD: begin
                pl_ready_d = 1'b1;
                if (pl_valid && pl_ready_q) begin
                    buf_wr_s = 1'b1;
                    par_d    = par_q ^ pl_data;
                    if (buf_wr_ptr_s == len_q - 6'd1) begin
                        state_d     = S_HEADER;
                        pl_ready_d  = 1'b0;
                        data_d      = hdr_byte(len_q, dest_q);
                        pkt_valid_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d  = S_PAYLOAD;
                    data_d   = buf_rd_data_s;
                    buf_rd_s = 1'b1;
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_PAYLOAD: begin
                // rd_ptr equals len once the final payload byte is on data.
                if (!busy) begin
                    if (buf_rd_ptr_s == len_q) begin
                        state_d     = S_PARITY;
                        data_d      = par_out_s;
                        pkt_valid_d = 1'b0;
                    end else begin
                        data_d   = buf_rd_data_s;
                        buf_rd_s = 1'b1;
                    end
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d = S_DONE;
                    data_d  = 8'h00;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                data_d      = 8'h00;
                pkt_valid_d = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                data_d      = 8'h00;
                pkt_valid_d = 1'b0;
            end
        endcase
        tx_busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dest_q      <= 2'b00;
            len_q       <= 6'd0;
            par_q       <= 8'h00;
            data_q      <= 8'h00;
            pkt_valid_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_busy_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            par_q       <= par_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            pl_ready_q  <= pl_ready_d;
            tx_busy_q   <= tx_busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data      = data_q;
    assign pkt_valid = pkt_valid_q;
    assign pl_ready  = pl_ready_q;
    assign tx_busy   = tx_busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed packets plus randomized
// traffic compared against a byte-stream reference model.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst, start, pl_valid, busy, inj_err;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] pl_data, data;
    logic       pl_ready, pkt_valid, tx_busy, done, err;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] pay   [64];
    logic [7:0] exp_b [66];
    logic       exp_v [66];

`ifdef ROUTER_TX_PARITY_INJ_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .data      (data),
        .pkt_valid (pkt_valid),
        .tx_busy   (tx_busy),
        .done      (done),
        .err       (err),
        .inj_err   (inj_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Send one packet; all waits are bounded and every presented byte is checked
    // against the expected stream {header, payload..., parity}.
    task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input bit rnd,
                              input int stall_idx, input int stall_len, input int abort_n,
                              input logic inj);
        logic [7:0] par;
        int  ln, n, acc, cyc, held;
        bit  fin, pres, first;
        ln  = int'(l);
        par = {l, d};
        exp_b[0] = par;
        exp_v[0] = 1'b1;
        for (int i = 0; i < ln; i++) begin
            exp_b[i+1] = pay[i];
            exp_v[i+1] = 1'b1;
            par = par ^ pay[i];
        end
        exp_b[ln+1] = (INJ_ON && inj) ? (par ^ 8'h01) : par;
        exp_v[ln+1] = 1'b0;

        n = 0; acc = 0; cyc = 0; held = 0; fin = 1'b0; first = 1'b0;
        inj_err = inj; dest = d; len = l; start = 1'b1; pl_valid = 1'b0; busy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            pl_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pl_data  = (acc < ln) ? pay[acc] : 8'($urandom);
            start    = (rnd && n <= ln) ? 1'($urandom) : 1'b0;
            dest     = 2'($urandom);
            len      = 6'($urandom);
            pres     = (n == 0) ? pkt_valid : 1'b1;
            chk("no_err", err, 0);
            if (pres && n == abort_n) begin
                rst = 1'b1; busy = 1'b0; pl_valid = 1'b0; start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_pv", pkt_valid, 0);
                chk("abort_busy", tx_busy, 0);
                chk("abort_data", data, 0);
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_done", done, 0);
                    chk("abort_idle", tx_busy, 0);
                end
                return;
            end
            if (pres) begin
                if (!first && !rnd) chk("latency", cyc, ln + 1);
                first = 1'b1;
                busy = rnd ? ($urandom_range(0, 2) == 0) : (n == stall_idx && held < stall_len);
                if (n == stall_idx) held++;
                chk("tx_busy", tx_busy, 1);
                chk("byte", data, exp_b[n]);
                chk("pkt_valid", pkt_valid, exp_v[n]);
                if (!busy) n++;
                if (n == ln + 2) fin = 1'b1;
            end else begin
                busy = rnd ? 1'($urandom) : 1'b0;
            end
            if (pl_valid && pl_ready) acc++;
        end
        chk("complete", fin, 1);
        chk("accepted", acc, ln);
        if (stall_len > 0) chk("stall_hold", held, stall_len + 1);
        @(negedge clk);
        busy = 1'b0; pl_valid = 1'b0; start = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_pv", pkt_valid, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_busy", tx_busy, 0);
        chk("idle_data", data, 0);
    endtask

    task automatic reject(input logic [1:0] d, input logic [5:0] l);
        dest = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_pv", pkt_valid, 0);
        chk("rej_busy", tx_busy, 0);
        @(negedge clk);
        chk("rej_err_clr", err, 0);
        chk("rej_idle", tx_busy, 0);
    endtask

    task automatic set_basic();
        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h0F;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dest = 2'b00; len = 6'd0; pl_data = 8'h00;
        pl_valid = 1'b0; busy = 1'b0; inj_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_pv", pkt_valid, 0);
        chk("rst_ready", pl_ready, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        // Start held together with reset must not launch a packet.
        start = 1'b1; dest = 2'b01; len = 6'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio", tx_busy, 0);
        @(negedge clk);

        set_basic();
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b0);
        set_basic();
        run_packet(2'd1, 6'd3, 1'b0, 2, 2, -1, 1'b0);
        reject(2'd3, 6'd5);
        reject(2'd0, 6'd0);
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        run_packet(2'd2, 6'd63, 1'b0, -1, 0, -1, 1'b0);
        set_basic();
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, 2, 1'b0);
        pay[0] = 8'h5A;
        run_packet(2'd0, 6'd1, 1'b0, -1, 0, -1, 1'b0);
        set_basic();
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            logic [5:0] rl;
            rl = (k % 5 == 0) ? 6'($urandom_range(1, 63)) : 6'($urandom_range(1, 12));
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            run_packet(2'($urandom_range(0, 2)), rl, 1'b1, -1, 0, -1, 1'($urandom));
            if (k % 7 == 3) reject(2'd3, 6'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
